// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the single-ported data memory between the CPU port (0) and a loader/debug port (1),
// alternating fairly under contention and letting port 1 lock the memory for bounded bursts.
module dm_arbiter #(
    parameter int MAX_LOCK = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [31:0] addr0,
    input  logic [31:0] wdata0,
    output logic [31:0] rdata0,
    output logic        ack0,
    input  logic        req1,
    input  logic        we1,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata1,
    output logic [31:0] rdata1,
    output logic        ack1,
    input  logic        lock1,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic [1:0]  owner
);
    typedef enum logic [1:0] {IDLE = 2'b00, OWN0 = 2'b01, OWN1 = 2'b10} state_t;
    state_t     state, state_nx;
    logic       last;
    logic [7:0] lock_cnt;
    logic [7:0] lock_max;
    assign lock_max  = 8'(MAX_LOCK - 1);
    assign owner     = state;
    assign ack0      = (state == OWN0) && req0;
    assign ack1      = (state == OWN1) && req1;
    assign mem_addr  = ack0 ? addr0 : ack1 ? addr1 : '0;
    assign mem_wdata = ack0 ? wdata0 : ack1 ? wdata1 : '0;
    assign mem_we    = (ack0 && we0) || (ack1 && we1);
    assign rdata0    = ack0 ? mem_rdata : '0;
    assign rdata1    = ack1 ? mem_rdata : '0;
    // Without an active owner, a tie goes to the port that was not served last.
    always_comb begin
        if (ack0) state_nx = req1 ? OWN1 : OWN0;
        else if (ack1) state_nx = (!req0 || (lock1 && lock_cnt < lock_max)) ? OWN1 : OWN0;
        else if (req0 && req1) state_nx = last ? OWN0 : OWN1;
        else state_nx = req0 ? OWN0 : req1 ? OWN1 : IDLE;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            last     <= 1'b1;
            lock_cnt <= '0;
        end else begin
            state <= state_nx;
            if (ack0 || ack1) last <= ack1;
            lock_cnt <= (ack1 && lock1 && req0 && state_nx == OWN1)
                        ? ((lock_cnt == lock_max) ? lock_cnt : lock_cnt + 8'd1) : '0;
        end
    end
endmodule

// File: tb/tb_dm_arbiter.sv
// tb_dm_arbiter: directed vector table plus hand-written reset and restart sequences for dm_arbiter,
// with a 1024-word memory that writes on the falling edge and reads combinationally.
module tb_dm_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
    logic [31:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
    logic        ack0, ack1, mem_we;
    logic [1:0]  owner;
    logic [31:0] mem [1024];
    int total = 0;
    int bad = 0;

    dm_arbiter #(.MAX_LOCK(4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .rdata0(rdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .rdata1(rdata1), .ack1(ack1),
        .lock1(lock1), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    always #5 clock = ~clock;
    always @(negedge clock) if (mem_we) mem[mem_addr[11:2]] <= mem_wdata;
    assign mem_rdata = mem[mem_addr[11:2]];

    typedef struct {
        logic r0, w0; logic [31:0] a0, d0;
        logic r1, w1; logic [31:0] a1, d1;
        logic lk;
        logic e_ack0, e_ack1, e_we; logic [1:0] e_own;
        logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
    } vec_t;
    vec_t tv[$];

    function automatic vec_t mk(logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                                logic r1, logic w1, logic [31:0] a1, logic [31:0] d1, logic lk,
                                logic e_ack0, logic e_ack1, logic e_we, logic [1:0] e_own,
                                logic [31:0] e_addr, logic [31:0] e_wd, logic [31:0] e_rd0,
                                logic [31:0] e_rd1);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
        v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1; v.lk = lk;
        v.e_ack0 = e_ack0; v.e_ack1 = e_ack1; v.e_we = e_we; v.e_own = e_own;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string nm, input vec_t v);
        chk({nm, "_ack0"}, 32'(ack0), 32'(v.e_ack0));
        chk({nm, "_ack1"}, 32'(ack1), 32'(v.e_ack1));
        chk({nm, "_mem_we"}, 32'(mem_we), 32'(v.e_we));
        chk({nm, "_owner"}, 32'(owner), 32'(v.e_own));
        chk({nm, "_mem_addr"}, mem_addr, v.e_addr);
        chk({nm, "_mem_wdata"}, mem_wdata, v.e_wd);
        chk({nm, "_rdata0"}, rdata0, v.e_rd0);
        chk({nm, "_rdata1"}, rdata1, v.e_rd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] D, A, F, P, Q;
        vec_t v;
        D = 32'hDEADBEEF; A = 32'hA0A0A0A0; F = 32'h55AA55AA; P = 32'h11111111; Q = 32'h22222222;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        // reset held with both ports requesting: everything stays quiet
        req0 = 1; we0 = 0; addr0 = 32'h40; wdata0 = Q;
        req1 = 1; we1 = 1; addr1 = 32'h44; wdata1 = P;
        #23;
        v = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk_all("in_reset", v);
        @(posedge clock); #1 reset = 1;
        #2 chk("released_owner", 32'(owner), 32'd0);
        // r0 w0 a0 d0 | r1 w1 a1 d1 | lk || ack0 ack1 we own addr wdata rd0 rd1
        tv.push_back(mk(1, 0, 32'h40, Q, 1, 1, 32'h44, P, 0, 1, 0, 0, 2'b01, 32'h40, Q, 0, 0));
        tv.push_back(mk(1, 1, 32'h10, D, 0, 1, 32'h44, P, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0));
        tv.push_back(mk(1, 1, 32'h10, D, 0, 1, 32'h44, P, 0, 1, 0, 1, 2'b01, 32'h10, D, 0, 0));
        tv.push_back(mk(1, 0, 32'h10, D, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 32'h10, D, D, 0));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 32'h10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 32'h10, 0, 0, 0, 1, 0, 2'b10, 32'h10, 0, 0, D));
        tv.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0));
        // contention, no lock: strict alternation
        tv.push_back(mk(1, 1, 32'h20, A, 1, 0, 32'h10, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++) begin
            tv.push_back(mk(1, 1, 32'h20, A, 1, 0, 32'h10, 0, 0, 1, 0, 1, 2'b01, 32'h20, A,
                            (k == 0) ? 32'h0 : A, 0));
            tv.push_back(mk(1, 1, 32'h20, A, 1, 0, 32'h10, 0, 0, 0, 1, 0, 2'b10, 32'h10, 0, 0, D));
        end
        // locked burst: port 1 keeps four grants while port 0 waits, then port 0 gets one
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 32'h30, F, 1, 0, 0, 0, 2'b01, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 1, 32'h30, F, 1, 0, 1, 1, 2'b10, 32'h30, F, 0, 0));
        for (int k = 0; k < 4; k++)
            tv.push_back(mk(1, 0, 32'h30, 0, 1, 1, 32'h30, F, 1, 0, 1, 1, 2'b10, 32'h30, F, 0, F));
        tv.push_back(mk(1, 0, 32'h30, 0, 1, 1, 32'h30, F, 1, 1, 0, 0, 2'b01, 32'h30, 0, F, 0));
        tv.push_back(mk(1, 0, 32'h30, 0, 1, 1, 32'h30, F, 1, 0, 1, 1, 2'b10, 32'h30, F, 0, F));
        // handover: port 0 drops req in the same cycle port 1 raises it
        tv.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0, 0, 0, 0));
        tv.push_back(mk(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2'b01, 32'h10, 0, D, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 0, 0, 2'b01, 0, 0, 0, 0));
        tv.push_back(mk(0, 0, 0, 0, 1, 0, 32'h20, 0, 0, 0, 1, 0, 2'b10, 32'h20, 0, 0, A));
        foreach (tv[i]) begin
            @(posedge clock); #1;
            req0 = tv[i].r0; we0 = tv[i].w0; addr0 = tv[i].a0; wdata0 = tv[i].d0;
            req1 = tv[i].r1; we1 = tv[i].w1; addr1 = tv[i].a1; wdata1 = tv[i].d1; lock1 = tv[i].lk;
            #2 chk_all($sformatf("t%0d", i), tv[i]);
        end
        // reset during a port-1 write, before the falling edge
        @(posedge clock); #1;
        req0 = 0; req1 = 1; we1 = 1; addr1 = 32'h50; wdata1 = 32'hCAFEF00D; lock1 = 0;
        #1 chk("midrst_pre_we", 32'(mem_we), 32'd1);
        #1 reset = 0;
        #1;
        v = mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        chk_all("midrst", v);
        @(negedge clock); #1 chk("midrst_word", mem[20], 32'h0);
        // arbitration restarts from IDLE with port 0 winning the first tie
        @(posedge clock); #1;
        reset = 1; req0 = 1; we0 = 0; addr0 = 32'h10; req1 = 1; we1 = 0; addr1 = 32'h20;
        #2 chk("restart_idle", 32'(owner), 32'd0);
        @(posedge clock); #3;
        chk("restart_ack0", 32'(ack0), 32'd1);
        chk("restart_ack1", 32'(ack1), 32'd0);
        chk("restart_rdata0", rdata0, D);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
